// File: rtl/npu_csr_ahb_slave_pkg.sv
// Shared constants, FSM state type and address decode for the NPU CSR AHB-Lite slave.
package npu_csr_pkg;

    localparam logic [11:0] CSR_CTRL    = 12'h000;
    localparam logic [11:0] CSR_STATUS  = 12'h004;
    localparam logic [11:0] CSR_RESULT  = 12'h008;
    localparam logic [11:0] CSR_SCRATCH = 12'h00C;

    localparam int CTRL_START     = 0;
    localparam int CTRL_IMG_LO    = 1;
    localparam int CTRL_IMG_HI    = 2;
    localparam int CTRL_TEST_MODE = 3;
    localparam int CTRL_IRQ_EN    = 4;

    localparam int STATUS_BUSY = 0;
    localparam int STATUS_DONE = 1;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD_WAIT,
        ST_RD_DATA,
        ST_ERR1,
        ST_ERR2
    } state_e;

    // A transfer is legal only as a full word to one of the four registers in our 4 KiB page.
    function automatic logic csr_access_legal(input logic [31:0] haddr,
                                              input logic [2:0]  hsize,
                                              input logic [19:0] base_page);
        logic reg_hit;
        reg_hit = (haddr[11:0] == CSR_CTRL)   || (haddr[11:0] == CSR_STATUS) ||
                  (haddr[11:0] == CSR_RESULT) || (haddr[11:0] == CSR_SCRATCH);
        return (haddr[31:12] == base_page) && (hsize == HSIZE_WORD) && reg_hit;
    endfunction

endpackage

// File: rtl/npu_csr_ahb_slave_if.sv
// AHB-Lite signal bundle between the system master and the NPU CSR slave.
interface npu_csr_ahb_slave_if;

    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic        hmastlock;
    logic [31:0] hwdata;
    logic        hready;
    logic        hresp;
    logic [31:0] hrdata;

    modport master (
        output haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hwdata,
        input  hready, hresp, hrdata
    );

    modport slave (
        input  haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hwdata,
        output hready, hresp, hrdata
    );

endinterface

// File: rtl/npu_csr_ahb_slave.sv
// AHB-Lite slave for the NPU control/status registers: zero-wait writes,
// one-wait-state reads, two-cycle ERROR response for illegal accesses.
module npu_csr_ahb_slave
    import npu_csr_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
    input  logic                clk,
    input  logic                reset,
    npu_csr_ahb_slave_if.slave  ahb,
    output logic                npu_start_o,
    output logic                npu_test_mode_o,
    output logic [1:0]          npu_test_img_index_o,
    input  logic                npu_busy_i,
    input  logic                npu_done_i,
    input  logic [4:0]          npu_class_i,
    input  logic [7:0]          npu_conf_i,
    output logic                irq_o
);

    state_e      state_q, state_d;
    logic [11:0] addr_q, addr_d;
    logic        hready, hresp;
    logic [31:0] hrdata_q, rd_data;

    logic [1:0]  ctrl_img_q;
    logic        ctrl_test_q, ctrl_irq_en_q;
    logic        status_done_q;
    logic [4:0]  result_class_q;
    logic [7:0]  result_conf_q;
    logic [31:0] scratch_q;
    logic        start_q;

    logic wr_en, wr_ctrl, wr_status, wr_scratch, legal;

    logic unused_bus;
    assign unused_bus = ^{ahb.hburst, ahb.hprot, ahb.hmastlock, ahb.htrans[0]};

    assign legal = csr_access_legal(ahb.haddr, ahb.hsize, BASE_ADDR[31:12]);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        hready  = 1'b1;
        hresp   = 1'b0;
        case (state_q)
            ST_RD_WAIT: begin
                hready  = 1'b0;
                state_d = ST_RD_DATA;
            end
            ST_ERR1: begin
                hready  = 1'b0;
                hresp   = 1'b1;
                state_d = ST_ERR2;
            end
            ST_ERR2: hresp = 1'b1;
            default: ;
        endcase
        // Any cycle with hready high is also an address phase for the next transfer.
        if (hready) begin
            state_d = ST_IDLE;
            if (ahb.htrans[1]) begin
                addr_d = ahb.haddr[11:0];
                if (!legal)          state_d = ST_ERR1;
                else if (ahb.hwrite) state_d = ST_WR;
                else                 state_d = ST_RD_WAIT;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    assign wr_en      = (state_q == ST_WR);
    assign wr_ctrl    = wr_en && (addr_q == CSR_CTRL);
    assign wr_status  = wr_en && (addr_q == CSR_STATUS);
    assign wr_scratch = wr_en && (addr_q == CSR_SCRATCH);

    always_comb begin
        rd_data = '0;
        case (addr_q)
            CSR_CTRL: begin
                rd_data[CTRL_IMG_HI:CTRL_IMG_LO] = ctrl_img_q;
                rd_data[CTRL_TEST_MODE]          = ctrl_test_q;
                rd_data[CTRL_IRQ_EN]             = ctrl_irq_en_q;
            end
            CSR_STATUS: begin
                rd_data[STATUS_BUSY] = npu_busy_i;
                rd_data[STATUS_DONE] = status_done_q;
            end
            CSR_RESULT:  rd_data = {16'h0, result_conf_q, 3'b000, result_class_q};
            CSR_SCRATCH: rd_data = scratch_q;
            default:     rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_img_q     <= '0;
            ctrl_test_q    <= 1'b0;
            ctrl_irq_en_q  <= 1'b0;
            status_done_q  <= 1'b0;
            result_class_q <= '0;
            result_conf_q  <= '0;
            scratch_q      <= '0;
            start_q        <= 1'b0;
            hrdata_q       <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl_img_q    <= ahb.hwdata[CTRL_IMG_HI:CTRL_IMG_LO];
                ctrl_test_q   <= ahb.hwdata[CTRL_TEST_MODE];
                ctrl_irq_en_q <= ahb.hwdata[CTRL_IRQ_EN];
            end
            if (wr_scratch) scratch_q <= ahb.hwdata;
            start_q <= wr_ctrl && ahb.hwdata[CTRL_START] && !npu_busy_i;
            // A completion in the same cycle as the W1C must not be lost.
            if (npu_done_i) begin
                status_done_q  <= 1'b1;
                result_class_q <= npu_class_i;
                result_conf_q  <= npu_conf_i;
            end else if (wr_status && ahb.hwdata[STATUS_DONE]) begin
                status_done_q <= 1'b0;
            end
            if (state_q == ST_RD_WAIT) hrdata_q <= rd_data;
        end
    end

    assign ahb.hready           = hready;
    assign ahb.hresp            = hresp;
    assign ahb.hrdata           = hrdata_q;
    assign npu_start_o          = start_q;
    assign npu_test_mode_o      = ctrl_test_q;
    assign npu_test_img_index_o = ctrl_img_q;
    assign irq_o                = status_done_q && ctrl_irq_en_q;

endmodule

// File: tb/tb_npu_csr_ahb_slave.sv
// Directed bench for npu_csr_ahb_slave: a vector table of single transfers plus
// hand-built sequences for start, done/W1C, idle cycles, pipelining and reset.
module tb_npu_csr_ahb_slave;
    import npu_csr_pkg::*;

    localparam logic [31:0] A_CTRL    = 32'h4000_0000;
    localparam logic [31:0] A_STATUS  = 32'h4000_0004;
    localparam logic [31:0] A_RESULT  = 32'h4000_0008;
    localparam logic [31:0] A_SCRATCH = 32'h4000_000C;

    logic       clk = 1'b0;
    logic       reset;
    logic       npu_start, npu_test_mode, irq;
    logic [1:0] npu_img_index;
    logic       npu_busy, npu_done;
    logic [4:0] npu_class;
    logic [7:0] npu_conf;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    npu_csr_ahb_slave_if bus ();

    npu_csr_ahb_slave dut (
        .clk                  (clk),
        .reset                (reset),
        .ahb                  (bus),
        .npu_start_o          (npu_start),
        .npu_test_mode_o      (npu_test_mode),
        .npu_test_img_index_o (npu_img_index),
        .npu_busy_i           (npu_busy),
        .npu_done_i           (npu_done),
        .npu_class_i          (npu_class),
        .npu_conf_i           (npu_conf),
        .irq_o                (irq)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transfer: address phase, then data phase until hready (bounded), then the closing edge.
    task automatic ahb_xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                            input logic [31:0] wdata, output logic resp_first,
                            output logic resp, output logic [31:0] rdata, output int waits);
        bus.htrans = HTRANS_NONSEQ;
        bus.haddr  = addr;
        bus.hwrite = wr;
        bus.hsize  = size;
        tick();
        bus.htrans = HTRANS_IDLE;
        bus.hwdata = wdata;
        waits      = 0;
        resp_first = bus.hresp;
        while (bus.hready !== 1'b1 && waits < 8) begin
            waits++;
            tick();
        end
        resp  = bus.hresp;
        rdata = bus.hrdata;
        tick();
    endtask

    task automatic wr_ok(input string name, input logic [31:0] addr, input logic [31:0] data);
        logic rf, r;
        logic [31:0] d;
        int w;
        ahb_xfer(1'b1, addr, HSIZE_WORD, data, rf, r, d, w);
        check({name, " resp"}, {31'h0, r}, 32'h0);
        check({name, " waits"}, w, 0);
    endtask

    task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic rf, r;
        logic [31:0] d;
        int w;
        ahb_xfer(1'b0, addr, HSIZE_WORD, 32'h0, rf, r, d, w);
        check({name, " resp"}, {31'h0, r}, 32'h0);
        check({name, " waits"}, w, 1);
        check({name, " rdata"}, d, exp);
    endtask

    task automatic done_pulse(input logic [4:0] cls, input logic [7:0] conf);
        npu_class = cls;
        npu_conf  = conf;
        npu_done  = 1'b1;
        tick();
        npu_done  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " hready"}, {31'h0, bus.hready}, 32'h1);
        check({name, " hresp"}, {31'h0, bus.hresp}, 32'h0);
        check({name, " hrdata"}, bus.hrdata, 32'h0);
        check({name, " start"}, {31'h0, npu_start}, 32'h0);
        check({name, " test_mode"}, {31'h0, npu_test_mode}, 32'h0);
        check({name, " img_index"}, {30'h0, npu_img_index}, 32'h0);
        check({name, " irq"}, {31'h0, irq}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        rf, r;
        logic [31:0] d;
        int          w;

        vecs[0]  = '{1'b1, A_SCRATCH,      HSIZE_WORD, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, A_SCRATCH,      HSIZE_WORD, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, A_SCRATCH,      3'b000,     32'h1111_1111, 1'b1, 32'h0};
        vecs[3]  = '{1'b0, A_SCRATCH,      HSIZE_WORD, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[4]  = '{1'b1, 32'h4000_0010,  HSIZE_WORD, 32'h2222_2222, 1'b1, 32'h0};
        vecs[5]  = '{1'b0, 32'h4000_0010,  HSIZE_WORD, 32'h0,         1'b1, 32'h0};
        vecs[6]  = '{1'b1, 32'h5000_000C,  HSIZE_WORD, 32'h3333_3333, 1'b1, 32'h0};
        vecs[7]  = '{1'b0, A_STATUS,       3'b001,     32'h0,         1'b1, 32'h0};
        vecs[8]  = '{1'b1, A_CTRL,         HSIZE_WORD, 32'h0000_001E, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, A_CTRL,         HSIZE_WORD, 32'h0,         1'b0, 32'h0000_001E};
        vecs[10] = '{1'b1, A_RESULT,       HSIZE_WORD, 32'hFFFF_FFFF, 1'b0, 32'h0};
        vecs[11] = '{1'b0, A_RESULT,       HSIZE_WORD, 32'h0,         1'b0, 32'h0};
        vecs[12] = '{1'b1, A_SCRATCH,      HSIZE_WORD, 32'h1234_5678, 1'b0, 32'h0};
        vecs[13] = '{1'b0, A_SCRATCH,      HSIZE_WORD, 32'h0,         1'b0, 32'h1234_5678};

        bus.haddr = '0; bus.hwrite = 1'b0; bus.hsize = HSIZE_WORD; bus.hburst = '0;
        bus.hprot = '0; bus.htrans = HTRANS_IDLE; bus.hmastlock = 1'b0; bus.hwdata = '0;
        npu_busy = 1'b0; npu_done = 1'b0; npu_class = '0; npu_conf = '0;
        reset = 1'b1;
        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();

        for (int i = 0; i < 14; i++) begin
            ahb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata, rf, r, d, w);
            check($sformatf("vec%0d resp_first", i), {31'h0, rf}, {31'h0, vecs[i].exp_err});
            check($sformatf("vec%0d resp", i), {31'h0, r}, {31'h0, vecs[i].exp_err});
            check($sformatf("vec%0d waits", i), w, (vecs[i].exp_err || !vecs[i].wr) ? 1 : 0);
            if (!vecs[i].wr && !vecs[i].exp_err)
                check($sformatf("vec%0d rdata", i), d, vecs[i].exp_rdata);
        end
        check("ctrl test_mode", {31'h0, npu_test_mode}, 32'h1);
        check("ctrl img_index", {30'h0, npu_img_index}, 32'h3);

        // START pulse lands in the cycle after WR and lasts one cycle.
        wr_ok("start wr", A_CTRL, 32'h0000_0005);
        check("start pulse", {31'h0, npu_start}, 32'h1);
        tick();
        check("start pulse end", {31'h0, npu_start}, 32'h0);
        check("start img_index", {30'h0, npu_img_index}, 32'h2);
        rd_check("ctrl rb", A_CTRL, 32'h0000_0004);

        npu_busy = 1'b1;
        wr_ok("start busy wr", A_CTRL, 32'h0000_0001);
        check("start suppressed", {31'h0, npu_start}, 32'h0);
        rd_check("status busy", A_STATUS, 32'h0000_0001);
        npu_busy = 1'b0;

        wr_ok("irq_en wr", A_CTRL, 32'h0000_0010);
        done_pulse(5'd17, 8'hC8);
        check("irq after done", {31'h0, irq}, 32'h1);
        rd_check("result", A_RESULT, 32'h0000_C811);
        rd_check("status done", A_STATUS, 32'h0000_0002);

        // W1C of DONE in the same cycle as a new completion: set wins.
        bus.htrans = HTRANS_NONSEQ; bus.haddr = A_STATUS; bus.hwrite = 1'b1; bus.hsize = HSIZE_WORD;
        tick();
        bus.htrans = HTRANS_IDLE; bus.hwdata = 32'h2;
        check("w1c race hready", {31'h0, bus.hready}, 32'h1);
        done_pulse(5'd3, 8'h11);
        rd_check("w1c race status", A_STATUS, 32'h0000_0002);
        rd_check("w1c race result", A_RESULT, 32'h0000_1103);
        wr_ok("w1c wr", A_STATUS, 32'h0000_0002);
        check("irq cleared", {31'h0, irq}, 32'h0);
        rd_check("status cleared", A_STATUS, 32'h0000_0000);

        // BUSY/IDLE beats never touch registers and never stall the bus.
        wr_ok("scratch a5", A_SCRATCH, 32'hA5A5_5A5A);
        bus.haddr = A_SCRATCH; bus.hwrite = 1'b1; bus.hwdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            bus.htrans = (i % 2 == 0) ? HTRANS_BUSY : HTRANS_IDLE;
            tick();
            check($sformatf("idle beat%0d hready", i), {31'h0, bus.hready}, 32'h1);
        end
        bus.htrans = HTRANS_IDLE;
        rd_check("scratch after idle", A_SCRATCH, 32'hA5A5_5A5A);

        // Write immediately followed by a read of the same register.
        bus.htrans = HTRANS_NONSEQ; bus.haddr = A_SCRATCH; bus.hwrite = 1'b1;
        tick();
        bus.hwrite = 1'b0; bus.hwdata = 32'hCAFE_F00D;
        check("b2b wr hready", {31'h0, bus.hready}, 32'h1);
        tick();
        bus.htrans = HTRANS_IDLE;
        check("b2b rd wait", {31'h0, bus.hready}, 32'h0);
        tick();
        check("b2b rd hready", {31'h0, bus.hready}, 32'h1);
        check("b2b rd data", bus.hrdata, 32'hCAFE_F00D);
        tick();

        // Reset in RD_WAIT aborts the transfer asynchronously.
        wr_ok("pre-reset ctrl", A_CTRL, 32'h0000_001E);
        done_pulse(5'd9, 8'h42);
        check("pre-reset irq", {31'h0, irq}, 32'h1);
        bus.htrans = HTRANS_NONSEQ; bus.haddr = A_SCRATCH; bus.hwrite = 1'b0;
        tick();
        bus.htrans = HTRANS_IDLE;
        check("rd_wait before reset", {31'h0, bus.hready}, 32'h0);
        #2 reset = 1'b1;
        #1 check_reset_outputs("mid reset");
        tick();
        reset = 1'b0;
        tick();
        rd_check("scratch after reset", A_SCRATCH, 32'h0);
        rd_check("ctrl after reset", A_CTRL, 32'h0);
        rd_check("result after reset", A_RESULT, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/npu_csr_ahb_slave.md
# npu_csr_ahb_slave

AHB-Lite slave that terminates bus transactions from the system's AHB master and exposes the NPU control/status register file. It decodes single word accesses, inserts one wait state on reads, and returns a two-cycle ERROR response for illegal accesses. It drives NPU-side control (start pulse, test mode, test image index) and captures NPU status and results.

## Interface
- BASE_ADDR, 32'h4000_0000, base of the 4 KiB register window (haddr[31:12] compare)
- clk  in  1  system clock, all logic rising-edge
- reset  in  1  asynchronous, active-high reset
- ahb_haddr_i  in  32  address-phase address
- ahb_hwrite_i  in  1  1 = write
- ahb_hsize_i  in  3  transfer size; only 3'b010 is legal
- ahb_hburst_i  in  3  ignored; every beat is treated as a single transfer
- ahb_hprot_i  in  4  ignored
- ahb_htrans_i  in  2  IDLE/BUSY are ignored; NONSEQ/SEQ are accepted
- ahb_hmastlock_i  in  1  ignored
- ahb_hwdata_i  in  32  data-phase write data
- ahb_hready_o  out  1  transfer done / bus ready (sole slave, used as HREADY)
- ahb_hresp_o  out  1  1 = ERROR
- ahb_hrdata_o  out  32  read data
- npu_start_o  out  1  one-cycle start pulse
- npu_test_mode_o  out  1  CTRL[3]
- npu_test_img_index_o  out  2  CTRL[2:1]
- npu_busy_i  in  1  NPU inference in progress
- npu_done_i  in  1  one-cycle completion pulse
- npu_class_i  in  5  result class, valid with done
- npu_conf_i  in  8  result confidence, valid with done
- irq_o  out  1  STATUS.DONE & CTRL.IRQ_EN

## Operation
- Registers (offset = haddr[11:0]):
  - 0x00 CTRL RW: [0] START (write 1 pulses, reads 0); [2:1] IMG_INDEX; [3] TEST_MODE; [4] IRQ_EN.
  - 0x04 STATUS: [0] BUSY (RO, live npu_busy_i); [1] DONE (sticky, W1C).
  - 0x08 RESULT RO: [4:0] class, [15:8] conf, captured on npu_done_i.
  - 0x0C SCRATCH RW, 32 bits.
- Legal access: htrans[1]=1, haddr[31:12]=BASE_ADDR[31:12], offset in {0x00, 0x04, 0x08, 0x0C}, hsize=3'b010. Anything else with htrans[1]=1 is ERROR. Writes to RO registers are ignored with an OKAY response.
- FSM states:
  - IDLE: sample the address phase when hready_o=1. A legal write goes to WR. A legal read goes to RD_WAIT. An illegal access goes to ERR1.
  - WR: hready_o=1; hwdata is committed at the end of this cycle. A new address phase is sampled in the same cycle, with the same decode as IDLE.
  - RD_WAIT: hready_o=0; hrdata is registered, then the FSM goes to RD_DATA.
  - RD_DATA: hready_o=1, hrdata valid, hresp=0; the next address phase is sampled.
  - ERR1: hready_o=0, hresp=1, then ERR2.
  - ERR2: hready_o=1, hresp=1. The next address phase is sampled.
- START: a write to CTRL with hwdata[0]=1 pulses npu_start_o the cycle after WR. The pulse is suppressed if npu_busy_i=1 during WR.
- DONE: set by npu_done_i. If npu_done_i and a W1C of DONE occur in the same cycle, set wins.

## Timing
- Reset values: hready_o=1, hresp_o=0, hrdata_o=0, npu_start_o=0, npu_test_mode_o=0, npu_test_img_index_o=0, irq_o=0, all registers 0, FSM=IDLE.
- Write latency: zero wait states; the register updates on the clock edge that ends the data phase.
- Read latency: one wait state; data is valid 2 cycles after the address phase.
- ERROR response: exactly 2 data-phase cycles.
- Back-to-back transfers: supported after WR, RD_DATA and ERR2 with no idle cycle.
- RESULT is captured on the same edge that sets DONE.
- Reset asserted mid-transfer: the FSM is forced to IDLE asynchronously and hready_o goes to 1 immediately; the transfer is aborted.

## Structure
- Package npu_csr_pkg: register offset localparams, CTRL/STATUS bit indices, HTRANS and HSIZE constants, FSM state enum.
- Single module; no sub-module is required. Address decode is a function in the package.

## Test plan
- Write CTRL=32'h0000_0005 with busy=0 -> zero-wait OKAY; npu_start_o high for 1 cycle; img_index=2'b10; CTRL reads back 32'h0000_0004.
- Read SCRATCH after writing 32'hDEAD_BEEF -> one cycle with hready_o=0, then hrdata=32'hDEAD_BEEF with hready_o=1.
- Byte write (hsize=0) to 0x0C -> ERR1 then ERR2 (hresp=1 both cycles, hready 0 then 1); SCRATCH unchanged. Offset 0x10 gives the same response.
- npu_done_i with class=5'd17 and conf=8'hC8, with IRQ_EN=1 -> irq_o=1; RESULT reads 32'h0000_C811. W1C of STATUS=32'h2 in the same cycle as a second done -> DONE stays 1.
- htrans=BUSY/IDLE cycles between writes -> no register change; hready_o stays 1.
- Reset asserted during RD_WAIT -> hready_o=1 and hresp_o=0 immediately; all outputs at their reset values.
